// File: rtl/layer_controller.sv
// Row sequencer for one fully-connected layer. It issues one multiplier job per output row,
// stores each row result, tracks per-row overflow and stops with an error if a row never completes.
module layer_controller #(
  parameter int NUM_ROWS = 10,
  parameter int TIMEOUT  = 512,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic                done_row,
  input  logic [15:0]         row_result,
  input  logic                overflow,
  output logic                begin_mult,
  output logic [3:0]          row_select,
  output logic                w_result_ena,
  output logic [3:0]          result_addr,
  output logic [15:0]         result_data,
  output logic                busy,
  output logic                layer_done,
  output logic                error,
  output logic [NUM_ROWS-1:0] overflow_flags
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          row_r;
  logic [WD_W-1:0]     wd_r;
  logic [15:0]         cap_result_r;
  logic                cap_ovf_r;
  logic [NUM_ROWS-1:0] flags_r;
  logic                launch_s;

  // A new layer may only be launched from IDLE or ERROR, and abort always wins.
  assign launch_s = start && !abort && (state_r == S_IDLE || state_r == S_ERROR);

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  if (start) state_s = S_ISSUE; else state_s = S_IDLE;
        S_ISSUE: state_s = S_WAIT;
        S_WAIT: begin
          if (done_row)            state_s = S_STORE;
          else if (wd_r == WD_LAST) state_s = S_ERROR;
          else                     state_s = S_WAIT;
        end
        S_STORE: if (row_r == LAST_ROW) state_s = S_DONE; else state_s = S_ISSUE;
        S_DONE:  state_s = S_IDLE;
        S_ERROR: if (start) state_s = S_ISSUE; else state_s = S_ERROR;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Row counter, watchdog, capture registers and sticky overflow bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_r        <= 4'd0;
      wd_r         <= '0;
      cap_result_r <= 16'd0;
      cap_ovf_r    <= 1'b0;
      flags_r      <= '0;
    end else if (launch_s) begin
      row_r   <= 4'd0;
      flags_r <= '0;
    end else begin
      case (state_r)
        S_ISSUE: wd_r <= '0;
        S_WAIT: begin
          wd_r <= wd_r + WD_W'(1);
          // Capture is suppressed on abort so the kept overflow flags stay untouched.
          if (done_row && !abort) begin
            cap_result_r <= row_result;
            cap_ovf_r    <= overflow;
            if (overflow) flags_r[row_r] <= 1'b1;
          end
        end
        S_STORE: if (!abort && row_r != LAST_ROW) row_r <= row_r + 4'd1;
        default: row_r <= row_r;
      endcase
    end
  end

  // Outputs are decoded from state and registers only; nothing flows straight from an input.
  assign begin_mult     = (state_r == S_ISSUE);
  assign w_result_ena   = (state_r == S_STORE);
  assign layer_done     = (state_r == S_DONE);
  assign error          = (state_r == S_ERROR);
  assign busy           = (state_r != S_IDLE) && (state_r != S_ERROR);
  assign row_select     = row_r;
  assign result_addr    = row_r;
  assign result_data    = (SATURATE && cap_ovf_r) ? 16'hFFFF : cap_result_r;
  assign overflow_flags = flags_r;

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: a multiplier model answers each begin_mult after a set latency and
// queues the expected store write; a monitor pops and compares every write against that queue.
module tb_layer_controller;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        done_row = 1'b0;
  logic [15:0] row_result = 16'd0;
  logic        overflow = 1'b0;

  logic        begin_mult, w_result_ena, busy, layer_done, error;
  logic [3:0]  row_select, result_addr;
  logic [15:0] result_data;
  logic [9:0]  overflow_flags;

  logic        begin_mult0, w_result_ena0, busy0, layer_done0, error0;
  logic [3:0]  row_select0, result_addr0;
  logic [15:0] result_data0;
  logic [9:0]  overflow_flags0;

  layer_controller #(.NUM_ROWS(10), .TIMEOUT(512), .SATURATE(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .done_row(done_row),
    .row_result(row_result), .overflow(overflow), .begin_mult(begin_mult),
    .row_select(row_select), .w_result_ena(w_result_ena), .result_addr(result_addr),
    .result_data(result_data), .busy(busy), .layer_done(layer_done), .error(error),
    .overflow_flags(overflow_flags)
  );

  // Identical stimulus into a non-saturating copy to see the raw value of an overflowed row.
  layer_controller #(.NUM_ROWS(10), .TIMEOUT(512), .SATURATE(1'b0)) dut_raw (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .done_row(done_row),
    .row_result(row_result), .overflow(overflow), .begin_mult(begin_mult0),
    .row_select(row_select0), .w_result_ena(w_result_ena0), .result_addr(result_addr0),
    .result_data(result_data0), .busy(busy0), .layer_done(layer_done0), .error(error0),
    .overflow_flags(overflow_flags0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] raw;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         ld_cnt = 0;
  int         bfm_lat = 395;
  int         silent_row = 15;
  int         ovf_row = 15;
  int         pend = 0;
  int         cnt = 0;
  int         exp_row = 0;
  logic [3:0] cur_row = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [31:0] ctl_bits();
    return {19'd0, begin_mult, w_result_ena, busy, layer_done, error, row_select, result_addr};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: answers each begin_mult bfm_lat cycles later and queues the expected write.
  always @(negedge clk) begin
    done_row   = 1'b0;
    overflow   = 1'b0;
    row_result = 16'd0;
    if (!n_rst || abort) begin
      pend = 0;
    end else begin
      if (start && !busy) exp_row = 0;
      if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin
          pend       = 0;
          done_row   = 1'b1;
          row_result = 16'(32'(cur_row) * 100);
          overflow   = (32'(cur_row) == ovf_row);
          exp_q.push_back('{cur_row, overflow ? 16'hFFFF : row_result, row_result});
        end
      end
      if (begin_mult) begin
        check_eq("row_sel", 32'(row_select), 32'(exp_row));
        exp_row++;
        if (32'(row_select) != silent_row) begin
          pend    = 1;
          cnt     = bfm_lat;
          cur_row = row_select;
        end
      end
    end
  end

  // Write monitor: every store strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    wr_t e;
    if (layer_done) ld_cnt++;
    if (w_result_ena) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", 32'(result_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(result_addr), 32'(e.addr));
        check_eq("wr_data", 32'(result_data), 32'(e.data));
        check_eq("wr_data_raw", 32'(result_data0), 32'(e.raw));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_layer(input string tag, input int budget);
    int  base;
    bit  ok;
    base = ld_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (ld_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_row(input string tag, input int r, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (begin_mult && 32'(row_select) == r) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int t0;
    #2;
    check_eq("rst_ctl", ctl_bits(), 32'd0);
    check_eq("rst_data", {6'd0, result_data, overflow_flags}, 32'd0);
    tick(2);
    n_rst = 1'b1;
    tick(2);

    // Full layer; a start pulse mid-layer must be ignored.
    pulse_start();
    wait_row("t1_row1_seen", 1, 1000);
    pulse_start();
    wait_layer("t1_layer", 6000);
    tick(1);
    check_eq("t1_ld_cnt", 32'(ld_cnt), 32'd1);
    check_eq("t1_rows", 32'(exp_row), 32'd10);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t1_flags", 32'(overflow_flags), 32'd0);

    // Overflow on row 3: saturated in one copy, raw 300 in the other.
    ovf_row = 3;
    pulse_start();
    wait_layer("t2_layer", 6000);
    tick(1);
    check_eq("t2_ld_cnt", 32'(ld_cnt), 32'd2);
    check_eq("t2_flags", 32'(overflow_flags), 32'h008);
    check_eq("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort while waiting on row 5.
    pulse_start();
    wait_row("t5_row5_seen", 5, 3000);
    tick(100);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'd0);
    tick(600);
    check_eq("t5_no_done", 32'(ld_cnt), 32'd2);
    check_eq("t5_flags_kept", 32'(overflow_flags), 32'h008);
    check_eq("t5_error", 32'(error), 32'd0);
    check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Row 2 never answers: error exactly 512 cycles into WAIT.
    ovf_row    = 15;
    silent_row = 2;
    pulse_start();
    wait_row("t3_row2_seen", 2, 2000);
    t0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (error) break;
    end
    check_eq("t3_err_latency", 32'(cyc - t0), 32'd513);
    check_eq("t3_error", 32'(error), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);
    tick(5);
    check_eq("t3_err_held", 32'(error), 32'd1);
    check_eq("t3_q_empty", 32'(exp_q.size()), 32'd0);
    silent_row = 15;
    pulse_start();
    check_eq("t3_err_clr", 32'(error), 32'd0);
    wait_layer("t3_restart_layer", 6000);
    tick(1);
    check_eq("t3_rows", 32'(exp_row), 32'd10);
    check_eq("t3_ld_cnt", 32'(ld_cnt), 32'd3);

    // done_row on the very cycle the watchdog expires.
    bfm_lat = 512;
    pulse_start();
    wait_layer("t4_layer", 7000);
    tick(1);
    check_eq("t4_error", 32'(error), 32'd0);
    check_eq("t4_rows", 32'(exp_row), 32'd10);
    check_eq("t4_ld_cnt", 32'(ld_cnt), 32'd4);
    check_eq("t4_q_empty", 32'(exp_q.size()), 32'd0);
    bfm_lat = 395;

    // Reset in the middle of row 4, then a clean layer.
    pulse_start();
    wait_row("t6_row4_seen", 4, 3000);
    tick(50);
    n_rst = 1'b0;
    #1;
    check_eq("t6_rst_ctl", ctl_bits(), 32'd0);
    check_eq("t6_rst_data", {6'd0, result_data, overflow_flags}, 32'd0);
    tick(3);
    n_rst = 1'b1;
    tick(2);
    pulse_start();
    wait_layer("t6_layer", 6000);
    tick(1);
    check_eq("t6_rows", 32'(exp_row), 32'd10);
    check_eq("t6_ld_cnt", 32'(ld_cnt), 32'd5);
    check_eq("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t6_error", 32'(error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
